// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding selects, load-use hold, and long-latency write scoreboard
// for the 5-stage pipeline.
module fwd_hazard_scoreboard #(
    parameter int NRD  = 2,
    parameter int AW   = 5,
    parameter int NSTG = 2,
    parameter int LQ   = 4,
    parameter int CW   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NRD*AW-1:0]          ex_rs,
    input  logic [NRD-1:0]             ex_rs_used,
    input  logic [NSTG-1:0]            stg_we,
    input  logic [NSTG*AW-1:0]         stg_rd,
    input  logic [NSTG-1:0]            stg_rdy,
    output logic [NRD*$clog2(NSTG+1)-1:0] fwd_sel,
    output logic                       ex_hold,
    input  logic                       id_valid,
    input  logic [NRD*AW-1:0]          id_rs,
    input  logic [NRD-1:0]             id_rs_used,
    input  logic                       id_we,
    input  logic [AW-1:0]              id_rd,
    input  logic                       id_long,
    output logic                       id_stall,
    input  logic                       lo_wb_valid,
    input  logic [AW-1:0]              lo_wb_rd,
    output logic                       lo_full,
    output logic [CW-1:0]              stall_cnt
);

    localparam int SW = $clog2(NSTG + 1);
    localparam int IW = (LQ > 1) ? $clog2(LQ) : 1;

    logic [LQ-1:0]  r_vld;
    logic [AW-1:0]  r_rd [LQ];
    logic [CW-1:0]  r_cnt;

    logic           w_raw;
    logic           w_waw;
    logic           w_full;
    logic           w_alloc;
    logic           w_afound;
    logic [IW-1:0]  w_aidx;

    // Bypass select per read port; scanning oldest to youngest lets the youngest win.
    always_comb begin
        fwd_sel = '0;
        for (int p = 0; p < NRD; p++) begin
            for (int k = NSTG - 1; k >= 0; k--) begin
                if (ex_rs_used[p] && stg_we[k]
                    && (stg_rd[k*AW +: AW] != '0)
                    && (stg_rd[k*AW +: AW] == ex_rs[p*AW +: AW])) begin
                    fwd_sel[p*SW +: SW] = SW'(k + 1);
                end
            end
        end
    end

    // Hold EX when the selected producer has not produced its result yet.
    always_comb begin
        ex_hold = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            for (int k = 0; k < NSTG; k++) begin
                if ((fwd_sel[p*SW +: SW] == SW'(k + 1)) && !stg_rdy[k]) begin
                    ex_hold = 1'b1;
                end
            end
        end
    end

    // RAW/WAW lookup against registered scoreboard state only.
    always_comb begin
        w_raw = 1'b0;
        w_waw = 1'b0;
        for (int e = 0; e < LQ; e++) begin
            for (int p = 0; p < NRD; p++) begin
                if (id_rs_used[p] && (id_rs[p*AW +: AW] != '0)
                    && r_vld[e] && (r_rd[e] == id_rs[p*AW +: AW])) begin
                    w_raw = 1'b1;
                end
            end
            if (id_we && (id_rd != '0) && r_vld[e] && (r_rd[e] == id_rd)) begin
                w_waw = 1'b1;
            end
        end
    end

    assign w_full   = &r_vld;
    assign lo_full  = w_full;
    assign id_stall = id_valid && (w_raw || w_waw || (id_long && w_full));
    assign w_alloc  = id_valid && id_long && id_we && (id_rd != '0)
                      && !id_stall && !ex_hold;

    // Lowest-index free entry for allocation.
    always_comb begin
        w_afound = 1'b0;
        w_aidx   = '0;
        for (int e = LQ - 1; e >= 0; e--) begin
            if (!r_vld[e]) begin
                w_afound = 1'b1;
                w_aidx   = IW'(e);
            end
        end
    end

    // Scoreboard update: free on writeback match, allocate on issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            for (int e = 0; e < LQ; e++) begin
                r_rd[e] <= '0;
            end
        end else begin
            for (int e = 0; e < LQ; e++) begin
                if (lo_wb_valid && (lo_wb_rd != '0) && r_vld[e]
                    && (r_rd[e] == lo_wb_rd)) begin
                    r_vld[e] <= 1'b0;
                end
            end
            if (w_alloc && w_afound) begin
                r_vld[w_aidx] <= 1'b1;
                r_rd[w_aidx]  <= id_rd;
            end
        end
    end

    // Saturating count of ID stall cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (id_stall && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_cnt;

endmodule
